obi_copy_initiator: RTL and testbench

OBI initiator (master) DMA-style copy engine that drives the same single-port OBI interface the SRAM responder serves (req/gnt/addr/we/be/wdata/rvalid/rdata).
Copies len_words_i 32-bit words from src_addr_i to dst_addr_i, ascending.

---
 rtl/obi_copy_initiator.sv | 176 +++++++++++++++++
 tb/tb_obi_copy_initiator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_copy_initiator.sv
// OBI initiator copy engine: moves words src -> dst, one access in flight.
// Optional fill mode (write a latched pattern to dst) under OBI_COPY_FILL_EN.
module obi_copy_initiator #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_END  = 32'h8000_4000,
  parameter int          LEN_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_words_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [3:0]       be_o,
  output logic [31:0]      wdata_o,
  input  logic             rvalid_i,
  input  logic [31:0]      rdata_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             fill_q, fill_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             fill_sel;
  logic [31:0]      fill_pat;
  logic [33:0]      span;
  logic             cfg_ok;

`ifdef OBI_COPY_FILL_EN
  assign fill_sel = fill_i;
  assign fill_pat = fill_data_i;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_i, fill_data_i};
  assign fill_sel = 1'b0;
  assign fill_pat = 32'h0;
`endif

  // 34-bit end-address math so a huge len cannot wrap past ADDR_END
  assign span = 34'(len_words_i) << 2;

  function automatic logic legal(input logic [31:0] a,
                                 input logic [33:0] s);
    return (a[1:0] == 2'b00) && (a >= ADDR_BASE) &&
           (({2'b00, a} + s) <= {2'b00, ADDR_END});
  endfunction

  assign cfg_ok = legal(dst_addr_i, span) &&
                  (fill_sel || legal(src_addr_i, span));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    err_d   = err_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          rem_d  = len_words_i;
          fill_d = fill_sel;
          data_d = fill_pat;
          err_d  = !cfg_ok;
          if (!cfg_ok || len_words_i == '0) state_d = DONE;
          else if (fill_sel)                state_d = WR_REQ;
          else                              state_d = RD_REQ;
        end
      end
      RD_REQ:  if (gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (rvalid_i) begin
          data_d  = rdata_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ:  if (gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (rvalid_i) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DONE;
          else if (fill_q)        state_d = WR_REQ;
          else                    state_d = RD_REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered: derived from the next state
    req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    we_d    = (state_d == WR_REQ);
    addr_d  = (state_d == RD_REQ) ? src_d :
              (state_d == WR_REQ) ? dst_d : addr_q;
    wdata_d = (state_d == WR_REQ) ? data_d : wdata_q;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    error_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      fill_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign be_o    = 4'hF;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_obi_copy_initiator.sv
// Directed bench for obi_copy_initiator with a 1-cycle-rvalid OBI responder.
// Fill-mode expectations follow OBI_COPY_FILL_EN.
module tb_obi_copy_initiator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_words_i;
  logic        fill_i;
  logic [31:0] fill_data_i;
  logic        busy_o, done_o, error_o;
  logic        req_o, gnt_i, we_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  be_o;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;

  int total = 0;
  int bad   = 0;

  obi_copy_initiator dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_words_i(len_words_i),
    .fill_i     (fill_i),
    .fill_data_i(fill_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .be_o       (be_o),
    .wdata_o    (wdata_o),
    .rvalid_i   (rvalid_i),
    .rdata_i    (rdata_i)
  );

  always #5 clk = ~clk;

  // responder memory; unwritten words read back as a pattern of their address
  logic [31:0] mem [4096];
  bit          wr  [4096];
  logic [31:0] log_addr [64];
  logic        log_we   [64];
  int          ng = 0;
  int          nreqcyc = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      rvalid_i <= 1'b0;
    end else begin
      rvalid_i <= req_o && gnt_i;
      if (req_o) nreqcyc <= nreqcyc + 1;
      if (req_o && gnt_i) begin
        log_addr[ng % 64] <= addr_o;
        log_we[ng % 64]   <= we_o;
        ng <= ng + 1;
        if (we_o) begin
          mem[addr_o[13:2]] <= wdata_o;
          wr[addr_o[13:2]]  <= 1'b1;
        end else begin
          rdata_i <= wr[addr_o[13:2]] ? mem[addr_o[13:2]] : pat(addr_o);
        end
      end
    end
  end

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return wr[a[13:2]] ? mem[a[13:2]] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // start an operation; cycle 0 is the start edge, done cycle returned
  task automatic run(input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n, input logic f,
                     input logic [31:0] fd, input int st_lo,
                     input int st_hi, input int rst_at,
                     output int dcyc, output logic derr);
    int lim;
    lim = (rst_at > 0) ? rst_at + 20 : 200;
    @(negedge clk);
    src_addr_i  = s;
    dst_addr_i  = d;
    len_words_i = n;
    fill_i      = f;
    fill_data_i = fd;
    start_i     = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    dcyc = -1;
    derr = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      gnt_i = !(k >= st_lo && k <= st_hi);
      if (k >= st_lo && k <= st_hi) begin
        chk("stall_req", 32'(req_o), 32'd1);
        chk("stall_addr", addr_o, s + 32'd4);
      end
      if (rst_at > 0 && k == rst_at) rst_i = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
      end
      if (done_o && dcyc < 0) begin
        dcyc = k;
        derr = error_o;
        if (rst_at <= 0) break;
      end
    end
    gnt_i = 1'b1;
  endtask

  int   dc;
  logic de;
  int   g0;
  int   r0;

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    gnt_i       = 1'b1;
    src_addr_i  = '0;
    dst_addr_i  = '0;
    len_words_i = '0;
    fill_i      = 1'b0;
    fill_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_o", 32'(req_o), 32'd0);
    chk("rst_we_o", 32'(we_o), 32'd0);
    chk("rst_busy_o", 32'(busy_o), 32'd0);
    chk("rst_done_o", 32'(done_o), 32'd0);
    chk("rst_error_o", 32'(error_o), 32'd0);
    chk("rst_addr_o", addr_o, 32'h0);
    chk("rst_wdata_o", wdata_o, 32'h0);
    chk("rst_be_o", 32'(be_o), 32'hF);
    rst_i = 1'b0;

    // plain copy, 4 words
    g0 = ng;
    run(32'h8000_0000, 32'h8000_0800, 16'd4, 1'b0, 32'h0,
        -1, -1, -1, dc, de);
    chk("copy_done_cyc", 32'(dc), 32'd17);
    chk("copy_err", 32'(de), 32'd0);
    chk("copy_nreq", 32'(ng - g0), 32'd8);
    for (int j = 0; j < 8; j++) begin
      chk("copy_log_addr", log_addr[(g0 + j) % 64],
          ((j % 2) ? 32'h8000_0800 : 32'h8000_0000) + 32'(4 * (j / 2)));
      chk("copy_log_we", 32'(log_we[(g0 + j) % 64]), 32'(j % 2));
    end
    for (int i = 0; i < 4; i++)
      chk("copy_data", rd_mem(32'h8000_0800 + 32'(4 * i)),
          pat(32'h8000_0000 + 32'(4 * i)));

    // grant withheld for 3 cycles on the second read
    run(32'h8000_0000, 32'h8000_0800, 16'd4, 1'b0, 32'h0,
        5, 7, -1, dc, de);
    chk("stall_done_cyc", 32'(dc), 32'd20);
    chk("stall_err", 32'(de), 32'd0);

    // len = 0
    r0 = nreqcyc;
    run(32'h8000_0000, 32'h8000_0800, 16'd0, 1'b0, 32'h0,
        -1, -1, -1, dc, de);
    chk("len0_done_cyc", 32'(dc), 32'd1);
    chk("len0_err", 32'(de), 32'd0);
    chk("len0_noreq", 32'(nreqcyc - r0), 32'd0);

    // misaligned source
    r0 = nreqcyc;
    run(32'h8000_0002, 32'h8000_0800, 16'd1, 1'b0, 32'h0,
        -1, -1, -1, dc, de);
    chk("unal_done_cyc", 32'(dc), 32'd1);
    chk("unal_err", 32'(de), 32'd1);
    chk("unal_noreq", 32'(nreqcyc - r0), 32'd0);

    // destination runs past the window end
    r0 = nreqcyc;
    run(32'h8000_0000, 32'h8000_3FFC, 16'd2, 1'b0, 32'h0,
        -1, -1, -1, dc, de);
    chk("oob_done_cyc", 32'(dc), 32'd1);
    chk("oob_err", 32'(de), 32'd1);
    chk("oob_noreq", 32'(nreqcyc - r0), 32'd0);

    // exact fit at the window end is legal
    run(32'h8000_0000, 32'h8000_3FFC, 16'd1, 1'b0, 32'h0,
        -1, -1, -1, dc, de);
    chk("edge_done_cyc", 32'(dc), 32'd5);
    chk("edge_err", 32'(de), 32'd0);

    // reset during WR_REQ of word 2, then a fresh copy
    run(32'h8000_0200, 32'h8000_2000, 16'd4, 1'b0, 32'h0,
        -1, -1, 7, dc, de);
    chk("rst_no_done", 32'(dc), 32'hFFFF_FFFF);
    run(32'h8000_0100, 32'h8000_2000, 16'd3, 1'b0, 32'h0,
        -1, -1, -1, dc, de);
    chk("post_rst_done_cyc", 32'(dc), 32'd13);
    for (int i = 0; i < 3; i++)
      chk("post_rst_data", rd_mem(32'h8000_2000 + 32'(4 * i)),
          pat(32'h8000_0100 + 32'(4 * i)));

    // fill request
    g0 = ng;
    run(32'h8000_0000, 32'h8000_1000, 16'd3, 1'b1, 32'hA5A5_A5A5,
        -1, -1, -1, dc, de);
`ifdef OBI_COPY_FILL_EN
    chk("fill_done_cyc", 32'(dc), 32'd7);
    chk("fill_nreq", 32'(ng - g0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("fill_we", 32'(log_we[(g0 + i) % 64]), 32'd1);
      chk("fill_data", rd_mem(32'h8000_1000 + 32'(4 * i)), 32'hA5A5_A5A5);
    end
`else
    chk("fill_done_cyc", 32'(dc), 32'd13);
    chk("fill_nreq", 32'(ng - g0), 32'd6);
    for (int i = 0; i < 3; i++)
      chk("fill_data", rd_mem(32'h8000_1000 + 32'(4 * i)),
          pat(32'h8000_0000 + 32'(4 * i)));
`endif
    chk("fill_err", 32'(de), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
